// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 256;
  localparam int FIFO_N  = 3;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    addr_t  addr;
    instr_t instr;
    logic   err;
  } fetch_rsp_t;

  // Circular pointer increment over the FIFO_N response slots
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_N - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response, flush and program-load signals between PC side and responder.
interface fetch_if;
  import cpu_pkg::*;

  logic   req_valid;
  logic   req_ready;
  addr_t  req_addr;
  logic   flush;
  logic   rsp_valid;
  logic   rsp_ready;
  addr_t  rsp_addr;
  instr_t rsp_instr;
  logic   rsp_err;
  logic   prog_we;
  addr_t  prog_addr;
  instr_t prog_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err
  );
endinterface

// File: rtl/fetch_rsp_fifo.sv
// 3-entry first-word-fall-through FIFO of fetch responses; head reads as zero when empty.
module fetch_rsp_fifo
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  fetch_rsp_t din_i,
  input  logic       pop_i,
  input  logic       clear_i,
  output fetch_rsp_t dout_o,
  output logic [1:0] count_o
);
  fetch_rsp_t mem_q [FIFO_N];
  logic [1:0] rd_q, wr_q, cnt_q, cnt_d;
  logic       do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign count_o = cnt_q;
  assign dout_o  = (cnt_q == 2'd0) ? '0 : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (!push_i && do_pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 2'd0;
      wr_q  <= 2'd0;
      cnt_q <= 2'd0;
    end else if (clear_i) begin
      rd_q  <= 2'd0;
      wr_q  <= 2'd0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  end

  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, cnt_q} <= 3'(FIFO_N));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    (push_i && !clear_i) |-> ({1'b0, cnt_q} < 3'(FIFO_N)));
endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction RAM with a one-stage read pipeline feeding an in-order response FIFO.
module instr_fetch_responder #(
  parameter int DEPTH = cpu_pkg::DEPTH
) (
  input logic    clk,
  input logic    reset_n,
  fetch_if.slave bus
);
  import cpu_pkg::*;

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  instr_t     mem [DEPTH];
  instr_t     rdata_q;
  logic       s1_vld_q, s1_vld_d;
  addr_t      s1_addr_q;
  logic       s1_err_q;
  logic [1:0] fifo_cnt;
  logic [2:0] occ;
  logic       accept, req_oob, prog_ok;
  fetch_rsp_t push_data, head;

  // Occupancy counts S1 as well, so req_ready never depends on rsp_ready
  assign occ           = {1'b0, fifo_cnt} + {2'b0, s1_vld_q};
  assign bus.req_ready = (occ < 3'(FIFO_N));
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_oob       = (32'(bus.req_addr) >= 32'(DEPTH));
  assign prog_ok       = bus.prog_we && (32'(bus.prog_addr) < 32'(DEPTH));
  assign s1_vld_d      = accept;

  // Nonblocking read + write on the same edge gives read-first behaviour
  always_ff @(posedge clk) begin
    if (prog_ok)            mem[bus.prog_addr[RAM_AW-1:0]] <= bus.prog_data;
    if (accept && !req_oob) rdata_q <= mem[bus.req_addr[RAM_AW-1:0]];
  end

  // A request taken in a flush cycle is the redirect target and survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_err_q  <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (accept) begin
        s1_addr_q <= bus.req_addr;
        s1_err_q  <= req_oob;
      end
    end
  end

  assign push_data = '{addr:  s1_addr_q,
                       instr: s1_err_q ? '0 : rdata_q,
                       err:   s1_err_q};

  fetch_rsp_fifo u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (s1_vld_q && !bus.flush),
    .din_i   (push_data),
    .pop_i   (bus.rsp_valid && bus.rsp_ready),
    .clear_i (bus.flush),
    .dout_o  (head),
    .count_o (fifo_cnt)
  );

  assign bus.rsp_valid = (fifo_cnt != 2'd0);
  assign bus.rsp_addr  = head.addr;
  assign bus.rsp_instr = head.instr;
  assign bus.rsp_err   = head.err;
endmodule
